// File: rtl/alarm_clock_pkg.sv
// Shared constants and types for the alarm clock.
//   CYCLES_PER_SEC_DEFAULT : default prescaler length (clocks per second tick)
//   *_WRAP                 : digit value at or above which a digit wraps to 0
//   HOUR_ONES_LAST         : hour ones value that ends the day when tens is at its wrap
//   hhmm_t                 : packed hours/minutes digits, used for time/alarm compare
package alarm_clock_pkg;

    localparam int CYCLES_PER_SEC_DEFAULT = 1;

    localparam int SEC_ONES_WRAP  = 9;
    localparam int SEC_TENS_WRAP  = 5;
    localparam int MIN_ONES_WRAP  = 9;
    localparam int MIN_TENS_WRAP  = 5;
    localparam int HOUR_ONES_WRAP = 7;
    localparam int HOUR_TENS_WRAP = 2;
    localparam int HOUR_ONES_LAST = 3;

    typedef struct packed {
        logic [1:0] h1;
        logic [2:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } hhmm_t;

endpackage

// File: rtl/alarm_clock_digit.sv
// One decimal-ish time digit: counts up when enabled, wraps to 0 once it has
// reached WRAP (>= so an out-of-range loaded value also wraps), and signals a
// carry to the next digit in the same cycle it wraps.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_en           : count enable (tick or carry from the lower digit)
//   i_force_wrap   : wrap on this enable regardless of value (day rollover)
//   i_load         : load i_load_val, takes priority over counting
//   o_q            : registered digit value
//   o_carry        : enabled and wrapping this cycle
module digit_counter
    import alarm_clock_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int WRAP  = SEC_ONES_WRAP
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_force_wrap,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_q,
    output logic             o_carry
);

    logic [WIDTH-1:0] r_q;
    logic             w_at_wrap;

    assign w_at_wrap = (r_q >= WIDTH'(WRAP)) || i_force_wrap;
    assign o_carry   = i_en && w_at_wrap;
    assign o_q       = r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_en) begin
            r_q <= w_at_wrap ? '0 : r_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/alarm_clock.sv
// 24-hour alarm clock with HH:MM:SS digit outputs.
//   clock, reset        : clock, async active-low reset
//   H_in1..M_in0        : digits used by LD_time / LD_alarm
//   LD_time             : load hours/minutes, clear seconds and prescaler
//   LD_alarm            : load alarm hours/minutes
//   STOP_alarm          : clear latched alarm
//   Alarm_ON            : alarm enable (low also clears the latch)
//   Alarm               : latched alarm flag
//   H_out1..S_out0      : registered current time digits
module alarm_clock
    import alarm_clock_pkg::*;
#(
    parameter int CYCLES_PER_SEC = CYCLES_PER_SEC_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] H_in1,
    input  logic [2:0] H_in0,
    input  logic [3:0] M_in1,
    input  logic [3:0] M_in0,
    input  logic       LD_time,
    input  logic       LD_alarm,
    input  logic       STOP_alarm,
    input  logic       Alarm_ON,
    output logic       Alarm,
    output logic [1:0] H_out1,
    output logic [2:0] H_out0,
    output logic [3:0] M_out1,
    output logic [3:0] M_out0,
    output logic [3:0] S_out1,
    output logic [3:0] S_out0
);

    localparam int PRESC_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CYCLES_PER_SEC - 1);

    logic [PRESC_W-1:0] r_presc;
    logic               w_tick;
    logic               w_c_s0, w_c_s1, w_c_m0, w_c_m1, w_c_h0;
    logic               w_h_rollover;
    hhmm_t              r_alarm_time;
    hhmm_t              w_now;
    hhmm_t              w_in;
    logic               w_match;
    logic               r_alarm;

    // A load restarts the second, so the tick is suppressed in that cycle.
    assign w_tick = (r_presc == PRESC_LAST) && !LD_time;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
        end else if (LD_time || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    // 23 -> 00: force hour ones to wrap; hour tens then wraps on its own carry.
    assign w_h_rollover = (H_out1 >= 2'(HOUR_TENS_WRAP)) && (H_out0 >= 3'(HOUR_ONES_LAST));

    digit_counter #(.WIDTH(4), .WRAP(SEC_ONES_WRAP)) u_s0 (
        .i_clk(clock), .i_rst_n(reset), .i_en(w_tick), .i_force_wrap(1'b0),
        .i_load(LD_time), .i_load_val(4'd0), .o_q(S_out0), .o_carry(w_c_s0));

    digit_counter #(.WIDTH(4), .WRAP(SEC_TENS_WRAP)) u_s1 (
        .i_clk(clock), .i_rst_n(reset), .i_en(w_c_s0), .i_force_wrap(1'b0),
        .i_load(LD_time), .i_load_val(4'd0), .o_q(S_out1), .o_carry(w_c_s1));

    digit_counter #(.WIDTH(4), .WRAP(MIN_ONES_WRAP)) u_m0 (
        .i_clk(clock), .i_rst_n(reset), .i_en(w_c_s1), .i_force_wrap(1'b0),
        .i_load(LD_time), .i_load_val(M_in0), .o_q(M_out0), .o_carry(w_c_m0));

    digit_counter #(.WIDTH(4), .WRAP(MIN_TENS_WRAP)) u_m1 (
        .i_clk(clock), .i_rst_n(reset), .i_en(w_c_m0), .i_force_wrap(1'b0),
        .i_load(LD_time), .i_load_val(M_in1), .o_q(M_out1), .o_carry(w_c_m1));

    digit_counter #(.WIDTH(3), .WRAP(HOUR_ONES_WRAP)) u_h0 (
        .i_clk(clock), .i_rst_n(reset), .i_en(w_c_m1), .i_force_wrap(w_h_rollover),
        .i_load(LD_time), .i_load_val(H_in0), .o_q(H_out0), .o_carry(w_c_h0));

    digit_counter #(.WIDTH(2), .WRAP(HOUR_TENS_WRAP)) u_h1 (
        .i_clk(clock), .i_rst_n(reset), .i_en(w_c_h0), .i_force_wrap(1'b0),
        .i_load(LD_time), .i_load_val(H_in1), .o_q(H_out1), .o_carry());

    assign w_in    = '{h1: H_in1, h0: H_in0, m1: M_in1, m0: M_in0};
    assign w_now   = '{h1: H_out1, h0: H_out0, m1: M_out1, m0: M_out0};
    assign w_match = (w_now == r_alarm_time) && (S_out1 == 4'd0) && (S_out0 == 4'd0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_alarm_time <= '0;
            r_alarm      <= 1'b0;
        end else begin
            if (LD_alarm) begin
                r_alarm_time <= w_in;
            end
            if (STOP_alarm || !Alarm_ON) begin
                r_alarm <= 1'b0;
            end else if (w_match) begin
                r_alarm <= 1'b1;
            end
        end
    end

    assign Alarm = r_alarm;

endmodule

// File: tb/tb_alarm_clock.sv
module tb_alarm_clock;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] H_in1 = '0;
    logic [2:0] H_in0 = '0;
    logic [3:0] M_in1 = '0;
    logic [3:0] M_in0 = '0;
    logic       LD_time = 1'b0, LD_time10 = 1'b0;
    logic       LD_alarm = 1'b0, STOP_alarm = 1'b0, Alarm_ON = 1'b0;

    logic       al_a, al_b;
    logic [1:0] h1_a, h1_b;
    logic [2:0] h0_a, h0_b;
    logic [3:0] m1_a, m1_b, m0_a, m0_b, s1_a, s1_b, s0_a, s0_b;

    alarm_clock #(.CYCLES_PER_SEC(1)) dut (
        .clock(clock), .reset(reset),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .STOP_alarm(STOP_alarm), .Alarm_ON(Alarm_ON),
        .Alarm(al_a), .H_out1(h1_a), .H_out0(h0_a), .M_out1(m1_a), .M_out0(m0_a),
        .S_out1(s1_a), .S_out0(s0_a));

    alarm_clock #(.CYCLES_PER_SEC(10)) dut10 (
        .clock(clock), .reset(reset),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time10), .LD_alarm(1'b0), .STOP_alarm(1'b0), .Alarm_ON(1'b0),
        .Alarm(al_b), .H_out1(h1_b), .H_out0(h0_b), .M_out1(m1_b), .M_out0(m0_b),
        .S_out1(s1_b), .S_out0(s0_b));

    always #5 clock = ~clock;

    int cyc = 0;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    typedef struct {
        int          cyc;
        bit          d10;
        logic [21:0] exp;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [21:0] tv(int h1, int h0, int m1, int m0, int s1, int s0, bit al);
        return {2'(h1), 3'(h0), 4'(m1), 4'(m0), 4'(s1), 4'(s0), al};
    endfunction

    function automatic string fmt(logic [21:0] v);
        return $sformatf("%0d%0d:%0d%0d:%0d%0d alarm=%0b",
                         v[21:20], v[19:17], v[16:13], v[12:9], v[8:5], v[4:1], v[0]);
    endfunction

    task automatic push(int d, bit d10, logic [21:0] v, string nm);
        exp_t e;
        e.cyc = cyc + d; e.d10 = d10; e.exp = v; e.nm = nm;
        sb.push_back(e);
    endtask

    // Monitor: at each falling edge, compare every expectation due this cycle.
    initial forever begin
        logic [21:0] act;
        @(negedge clock);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                act = sb[i].d10 ? {h1_b, h0_b, m1_b, m0_b, s1_b, s0_b, al_b}
                                : {h1_a, h0_a, m1_a, m0_a, s1_a, s0_a, al_a};
                n_vec++;
                if (sb[i].cyc < cyc) begin
                    n_bad++;
                    $display("FAIL %s: missed check cycle %0d (now %0d)", sb[i].nm, sb[i].cyc, cyc);
                end else if (act !== sb[i].exp) begin
                    n_bad++;
                    $display("FAIL %s @cyc %0d: got %s, want %s", sb[i].nm, cyc, fmt(act), fmt(sb[i].exp));
                end
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(int h1, int h0, int m1, int m0);
        H_in1 = 2'(h1); H_in0 = 3'(h0); M_in1 = 4'(m1); M_in0 = 4'(m0);
    endtask

    // Returns just after the load edge; cyc is then the load cycle.
    task automatic load_time(int h1, int h0, int m1, int m0);
        set_in(h1, h0, m1, m0);
        LD_time = 1'b1;
        step();
        LD_time = 1'b0;
    endtask

    initial begin
        step();                                             // cyc 1, still in reset
        push(0, 0, tv(0,0,0,0,0,0,0), "reset_init");
        push(0, 1, tv(0,0,0,0,0,0,0), "reset_init_10");
        reset = 1'b1;
        push(1, 0, tv(0,0,0,0,0,1,0), "first_tick");
        push(9, 1, tv(0,0,0,0,0,0,0), "presc10_before_tick");
        push(10, 1, tv(0,0,0,0,0,1,0), "presc10_first_tick");
        step();

        load_time(1, 2, 3, 4);
        push(0, 0, tv(1,2,3,4,0,0,0), "load_1234");
        push(55, 0, tv(1,2,3,4,5,5,0), "run_to_123455");
        repeat (56) step();                                 // edge just produced 12:34:56
        reset = 1'b0;
        push(0, 0, tv(0,0,0,0,0,0,0), "async_reset");
        push(0, 1, tv(0,0,0,0,0,0,0), "async_reset_10");
        step();
        reset = 1'b1;

        set_in(0, 7, 0, 0);
        LD_alarm = 1'b1;
        step();
        LD_alarm = 1'b0;
        push(0, 0, tv(0,0,0,0,0,1,0), "ld_alarm_tick");
        Alarm_ON = 1'b1;
        load_time(0, 6, 5, 9);
        push(0, 0, tv(0,6,5,9,0,0,0), "load_0659");
        push(60, 0, tv(0,7,0,0,0,0,0), "reach_0700");
        push(61, 0, tv(0,7,0,0,0,1,1), "alarm_set");
        push(62, 0, tv(0,7,0,0,0,2,1), "alarm_latched");
        push(63, 0, tv(0,7,0,0,0,3,0), "stop_clears");
        push(64, 0, tv(0,7,0,0,0,4,0), "stop_stays_clear");
        push(70, 0, tv(0,7,0,0,1,0,0), "stop_stays_clear_0710");
        repeat (62) step();
        STOP_alarm = 1'b1;
        step();
        STOP_alarm = 1'b0;
        repeat (7) step();

        Alarm_ON = 1'b0;
        load_time(0, 6, 5, 9);
        push(60, 0, tv(0,7,0,0,0,0,0), "off_reach_0700");
        push(61, 0, tv(0,7,0,0,0,1,0), "off_no_alarm");
        repeat (61) step();

        Alarm_ON = 1'b1;
        load_time(0, 7, 0, 0);
        push(0, 0, tv(0,7,0,0,0,0,0), "load_eq_alarm");
        push(1, 0, tv(0,7,0,0,0,1,1), "load_eq_alarm_set");
        push(2, 0, tv(0,7,0,0,0,2,1), "held_before_off");
        push(3, 0, tv(0,7,0,0,0,3,0), "alarm_on_drop_clears");
        step();
        step();
        Alarm_ON = 1'b0;
        step();

        Alarm_ON = 1'b1;
        STOP_alarm = 1'b1;
        load_time(0, 7, 0, 0);
        push(1, 0, tv(0,7,0,0,0,1,0), "stop_beats_match");
        push(2, 0, tv(0,7,0,0,0,2,0), "stop_beats_match_after");
        step();
        STOP_alarm = 1'b0;
        step();
        Alarm_ON = 1'b0;

        load_time(2, 3, 5, 9);
        push(0, 0, tv(2,3,5,9,0,0,0), "load_2359");
        push(60, 0, tv(0,0,0,0,0,0,0), "day_rollover");
        push(61, 0, tv(0,0,0,0,0,1,0), "after_rollover");
        repeat (61) step();

        load_time(0, 7, 5, 9);
        push(60, 0, tv(1,0,0,0,0,0,0), "hour_0759_to_1000");
        repeat (60) step();

        load_time(1, 7, 5, 9);
        push(60, 0, tv(2,0,0,0,0,0,0), "hour_1759_to_2000");
        repeat (60) step();

        load_time(0, 5, 1, 12);
        push(0, 0, tv(0,5,1,12,0,0,0), "load_out_of_range");
        push(60, 0, tv(0,5,2,0,0,0,0), "out_of_range_wraps");
        repeat (60) step();

        Alarm_ON = 1'b1;
        set_in(0, 6, 1, 5);
        LD_time = 1'b1;
        LD_alarm = 1'b1;
        step();
        LD_time = 1'b0;
        LD_alarm = 1'b0;
        push(0, 0, tv(0,6,1,5,0,0,0), "load_both");
        push(1, 0, tv(0,6,1,5,0,1,1), "load_both_alarm");
        step();
        Alarm_ON = 1'b0;

        set_in(1, 2, 3, 4);
        LD_time10 = 1'b1;
        step();
        LD_time10 = 1'b0;
        push(0, 1, tv(1,2,3,4,0,0,0), "p10_load");
        push(9, 1, tv(1,2,3,4,0,0,0), "p10_hold");
        push(10, 1, tv(1,2,3,4,0,1,0), "p10_tick1");
        push(19, 1, tv(1,2,3,4,0,1,0), "p10_hold2");
        push(20, 1, tv(1,2,3,4,0,2,0), "p10_tick2");
        repeat (22) step();

        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alarm_clock.md
ALARM_CLOCK -- requirements
Module: alarm_clock

Interface
REQ-001 SHALL have parameter: CYCLES_PER_SEC, default 1, clock cycles per one-second tick (>=1).
REQ-002 SHALL have ports:
- clock  in  1  sole clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low.
- H_in1  in  2  hour tens digit to load.
- H_in0  in  3  hour ones digit to load.
- M_in1  in  4  minute tens digit to load.
- M_in0  in  4  minute ones digit to load.
- LD_time  in  1  load current time.
- LD_alarm  in  1  load alarm time.
- STOP_alarm  in  1  clear active alarm.
- Alarm_ON  in  1  alarm enable.
- Alarm  out  1  alarm active flag.
- H_out1  out  2  current hour tens digit.
- H_out0  out  3  current hour ones digit.
- M_out1  out  4  current minute tens digit.
- M_out0  out  4  current minute ones digit.
- S_out1  out  4  current second tens digit.
- S_out0  out  4  current second ones digit.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 SHALL generate a one-cycle tick every CYCLES_PER_SEC clocks via a prescaler counting 0..CYCLES_PER_SEC-1; tick fires when count = CYCLES_PER_SEC-1.
REQ-005 SHALL hold time as six registered digits driven directly to the outputs (no combinational path from inputs to outputs).
REQ-006 On tick: S_out0 +1; S_out0 >= 9 wraps to 0 and carries into S_out1; S_out1 >= 5 with carry wraps to 0 and carries into minutes.
REQ-007 Minutes SHALL count identically to seconds (ones wrap at 9, tens wrap at 5), carrying into hours.
REQ-008 Hour ones SHALL wrap at 7 (3-bit limit) and carry into hour tens; at H_out1=2 and H_out0=3 a carry wraps hours to 00; sequence 00..07, 10..17, 20..23, 00.
REQ-009 LD_time high at an edge SHALL load H_in1/H_in0/M_in1/M_in0 into the hour/minute digits, clear seconds to 00, clear the prescaler; no tick applied that cycle.
REQ-010 LD_alarm high at an edge SHALL load the inputs into alarm registers (alarm seconds fixed at 00); LD_time and LD_alarm together SHALL both take effect.
REQ-011 Loaded digits SHALL NOT be range-checked; an out-of-range digit wraps to 0 on its next carry (>= comparison).
REQ-012 Match = current hours and minutes equal alarm registers and seconds = 00.
REQ-013 Alarm SHALL set at the edge after a cycle where Match and Alarm_ON are high, and stay latched after Match ends.
REQ-014 Alarm SHALL clear at the edge where STOP_alarm is high or Alarm_ON is low; clear has priority over set.
REQ-015 Loading a time equal to the alarm time with Alarm_ON high SHALL raise Alarm one cycle later.

Reset
REQ-016 While reset is low: all time digits 0, alarm registers 0, prescaler 0, Alarm 0, immediately and asynchronously.
REQ-017 First tick after release SHALL occur CYCLES_PER_SEC edges later.

Structure
REQ-018 Digit limits (9, 5, 7, 2, 3) and CYCLES_PER_SEC default SHALL live in shared package alarm_clock_pkg.
REQ-019 One sub-module, digit_counter (parameterized wrap value, enable-in, load, carry-out), SHALL be instantiated per digit; prescaler, alarm registers and alarm latch stay in alarm_clock.

Verification (CYCLES_PER_SEC=1)
REQ-020 Assert reset low mid-count at 12:34:56 -> all outputs 0 and Alarm 0 with no clock edge.
REQ-021 LD_time 06:59, LD_alarm 07:00, Alarm_ON=1 -> 60 ticks later outputs 07:00:00; Alarm=1 on next edge.
REQ-022 With Alarm latched, pulse STOP_alarm one cycle -> Alarm=0 next edge; stays 0 while time advances past 07:00:01.
REQ-023 Load 23:59, run 60 ticks -> 00:00:00; load 07:59 -> 60 ticks later 10:00:00.
REQ-024 Alarm_ON=0 at match 07:00:00 -> Alarm stays 0; drop Alarm_ON while Alarm latched -> Alarm=0 next edge.
REQ-025 CYCLES_PER_SEC=10: after LD_time, S_out0 increments exactly every 10 edges.
